// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the simple_cpu data-memory slave.
package cpu_mem_pkg;

  localparam int unsigned MAX_WAIT   = 15;
  localparam int unsigned WAIT_W     = 4;
  localparam int unsigned MEM_ADDR_W = 8;
  localparam int unsigned MEM_DATA_W = 16;

  typedef enum logic [1:0] {
    MS_IDLE,
    MS_WAIT,
    MS_RESP
  } mem_state_e;

  // One captured CPU access: direction, word address and write data.
  typedef struct packed {
    logic                  we;
    logic [MEM_ADDR_W-1:0] addr;
    logic [MEM_DATA_W-1:0] wdata;
  } mem_access_t;

  // Wait-state count loaded into the down-counter; limited to what the counter holds.
  function automatic logic [WAIT_W-1:0] clamp_wait(input int unsigned cycles);
    return (cycles > MAX_WAIT) ? WAIT_W'(MAX_WAIT) : WAIT_W'(cycles);
  endfunction

endpackage

// File: rtl/mem_array.sv
// DEPTH x DATA_W storage with one write port and one registered read port.
// Storage is never reset; only the read-data register is.
module mem_array #(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [IDX_W-1:0]  i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Write port: caller only enables it for in-range addresses.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Read register: holds the word only for the cycle after a read strobe, zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (i_re) begin
      r_rdata <= r_mem[i_raddr];
    end else begin
      r_rdata <= '0;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_slave.sv
// Data memory answering the simple_cpu mem_req/mem_ready handshake with a
// fixed number of wait states, a sticky out-of-range flag and access counters.
module data_mem_slave
  import cpu_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = MEM_ADDR_W,
  parameter int unsigned DATA_W      = MEM_DATA_W,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_req,
  input  logic              mem_we,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_ready,
  output logic              err,
  output logic [CNT_W-1:0]  rd_count,
  output logic [CNT_W-1:0]  wr_count
);

  localparam int unsigned       IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = clamp_wait(WAIT_CYCLES);
  localparam bit                WAIT_ZERO = (WAIT_INIT == '0);

  mem_state_e             r_state;
  logic [WAIT_W-1:0]      r_wait_cnt;
  mem_access_t            r_acc;
  logic                   r_armed;
  logic                   r_ready;
  logic                   r_err;
  logic [CNT_W-1:0]       r_rd_count;
  logic [CNT_W-1:0]       r_wr_count;

  mem_access_t            w_acc;
  logic                   w_accept;
  logic                   w_enter_resp;
  logic                   w_in_range;
  logic                   w_mem_we;
  logic                   w_mem_re;
  logic [IDX_W-1:0]       w_idx;
  logic [MEM_DATA_W-1:0]  w_rdata;

  // Access in flight: live bus while idle (zero-wait commits on the capture edge), captured copy otherwise.
  always_comb begin
    w_acc = r_acc;
    if (r_state == MS_IDLE) begin
      w_acc.we    = mem_we;
      w_acc.addr  = MEM_ADDR_W'(mem_addr);
      w_acc.wdata = MEM_DATA_W'(mem_wdata);
    end
  end

  // r_armed keeps requests out until the first edge after reset release,
  // so a request held across reset can never reach the array.
  assign w_accept     = r_armed && mem_req && (r_state == MS_IDLE);
  assign w_enter_resp = (w_accept && WAIT_ZERO) ||
                        ((r_state == MS_WAIT) && (r_wait_cnt == WAIT_W'(1)));
  assign w_in_range   = (32'(w_acc.addr) < DEPTH);
  assign w_mem_we     = w_enter_resp && w_acc.we  && w_in_range;
  assign w_mem_re     = w_enter_resp && !w_acc.we && w_in_range;
  assign w_idx        = IDX_W'(w_acc.addr);

  mem_array #(
    .DEPTH  (DEPTH),
    .IDX_W  (IDX_W),
    .DATA_W (MEM_DATA_W)
  ) u_mem_array (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_mem_we),
    .i_waddr (w_idx),
    .i_wdata (w_acc.wdata),
    .i_re    (w_mem_re),
    .i_raddr (w_idx),
    .o_rdata (w_rdata)
  );

  // Handshake FSM with wait counter, capture registers, error flag and statistics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= MS_IDLE;
      r_wait_cnt <= '0;
      r_acc      <= '0;
      r_armed    <= 1'b0;
      r_ready    <= 1'b0;
      r_err      <= 1'b0;
      r_rd_count <= '0;
      r_wr_count <= '0;
    end else begin
      r_armed <= 1'b1;
      r_ready <= 1'b0;

      case (r_state)
        MS_IDLE: begin
          if (w_accept) begin
            r_acc      <= w_acc;
            r_wait_cnt <= WAIT_INIT;
            r_state    <= WAIT_ZERO ? MS_RESP : MS_WAIT;
          end
        end
        MS_WAIT: begin
          r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
          if (r_wait_cnt == WAIT_W'(1)) begin
            r_state <= MS_RESP;
          end
        end
        MS_RESP: begin
          r_state <= MS_IDLE;
        end
        default: begin
          r_state <= MS_IDLE;
        end
      endcase

      if (w_enter_resp) begin
        r_ready <= 1'b1;
        if (!w_in_range) begin
          r_err <= 1'b1;
        end else if (w_acc.we) begin
          if (r_wr_count != {CNT_W{1'b1}}) begin
            r_wr_count <= r_wr_count + CNT_W'(1);
          end
        end else begin
          if (r_rd_count != {CNT_W{1'b1}}) begin
            r_rd_count <= r_rd_count + CNT_W'(1);
          end
        end
      end
    end
  end

  assign mem_rdata = DATA_W'(w_rdata);
  assign mem_ready = r_ready;
  assign err       = r_err;
  assign rd_count  = r_rd_count;
  assign wr_count  = r_wr_count;

endmodule
